// File: rtl/audioqsys_simplified_leds.sv
// Avalon-MM LED/actuator output port with a self-timed pulse mask ORed over the base value.
// Define AUDIOQSYS_LEDS_READBACK_EN to make DATA and PULSE_LEN readable at addresses 0 and 1.
module audioqsys_simplified_leds #(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned PULSE_CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {StIdle, StPulse} state_e;

  state_e                 r_state, w_state_next;
  logic [WIDTH-1:0]       r_data;
  logic [WIDTH-1:0]       r_mask, w_mask_next;
  logic [PULSE_CNT_W-1:0] r_pulse_len;
  logic [PULSE_CNT_W-1:0] r_cnt, w_cnt_next;
  logic                   r_overrun;
  logic                   w_ovr_set;
  logic                   w_wr, w_wr_data, w_wr_len, w_trig, w_wr_status;
  logic                   w_busy;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_data   = w_wr && (address == 2'd0);
  assign w_wr_len    = w_wr && (address == 2'd1);
  assign w_trig      = w_wr && (address == 2'd2);
  assign w_wr_status = w_wr && (address == 2'd3);
  assign w_busy      = (r_state == StPulse);
  assign w_unused    = ^writedata;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_mask_next  = r_mask;
    w_ovr_set    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_trig && (r_pulse_len != '0)) begin
          w_state_next = StPulse;
          w_cnt_next   = r_pulse_len;
          w_mask_next  = writedata[WIDTH-1:0];
        end
      end
      StPulse: begin
        // A trigger while busy is dropped and only flagged.
        w_ovr_set = w_trig;
        if (r_cnt == PULSE_CNT_W'(1)) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
          w_mask_next  = '0;
        end else begin
          w_cnt_next = r_cnt - PULSE_CNT_W'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (address)
`ifdef AUDIOQSYS_LEDS_READBACK_EN
      2'd0:    w_rdata = 32'(r_data);
      2'd1:    w_rdata = 32'(r_pulse_len);
`else
      2'd0:    w_rdata = '0;
      2'd1:    w_rdata = '0;
`endif
      2'd2:    w_rdata = '0;
      2'd3:    w_rdata = {30'd0, r_overrun, w_busy};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_data      <= '0;
      r_pulse_len <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_overrun   <= 1'b0;
      readdata    <= '0;
      out_port    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mask   <= w_mask_next;
      r_cnt    <= w_cnt_next;
      readdata <= w_rdata;
      out_port <= r_data | (w_busy ? r_mask : '0);
      if (w_wr_data) r_data <= writedata[WIDTH-1:0];
      if (w_wr_len)  r_pulse_len <= writedata[PULSE_CNT_W-1:0];
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (w_wr_status && writedata[1]) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule
